// File: rtl/axis_bitmap_to_image_downsizer.sv
// Strips a fixed number of leading 64-bit header lanes from each wide bitmap
// packet and re-emits the remaining payload lanes one per beat on a narrow stream.
module axis_bitmap_to_image_downsizer #(
  parameter int TDATA_WIDTH  = 256,
  parameter int TUSER_WIDTH  = 128,
  parameter int HEADER_LANES = 7
) (
  input  logic                      axis_aclk,
  input  logic                      axis_resetn,
  input  logic [TDATA_WIDTH-1:0]    axis_bitmap_tdata,
  input  logic [TDATA_WIDTH/8-1:0]  axis_bitmap_tkeep,
  input  logic [TUSER_WIDTH-1:0]    axis_bitmap_tuser,
  input  logic                      axis_bitmap_tvalid,
  output logic                      axis_bitmap_tready,
  input  logic                      axis_bitmap_tlast,
  output logic [TDATA_WIDTH/4-1:0]  axis_image_tdata,
  output logic [TDATA_WIDTH/32-1:0] axis_image_tkeep,
  output logic [TUSER_WIDTH-1:0]    axis_image_tuser,
  output logic                      axis_image_tvalid,
  input  logic                      axis_image_tready,
  output logic                      axis_image_tlast,
  output logic                      pkt_dropped
);

  localparam int LANES  = 4;
  localparam int LANE_W = TDATA_WIDTH / LANES;
  localparam int LANE_K = LANE_W / 8;
  localparam logic [9:0] HDR_LIM = 10'(HEADER_LANES);

  function automatic logic [1:0] lowest_idx(input logic [LANES-1:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [LANES-1:0] highest_bit(input logic [LANES-1:0] m);
    logic [LANES-1:0] r;
    r = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) begin
        r    = {LANES{1'b0}};
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic is_onehot(input logic [LANES-1:0] m);
    return (m != {LANES{1'b0}}) && ((m & (m - {{(LANES-1){1'b0}}, 1'b1})) == {LANES{1'b0}});
  endfunction

  logic [TDATA_WIDTH-1:0]   data_r;
  logic [TDATA_WIDTH/8-1:0] keep_r;
  logic [TUSER_WIDTH-1:0]   user_r;
  logic [LANES-1:0]         mask_r;
  logic [LANES-1:0]         last_r;
  logic [7:0]               hdr_cnt_r;
  logic                     seen_r;
  logic                     drop_r;

  logic [LANES-1:0] emit_s;
  logic [LANES-1:0] sel_oh_s;
  logic [1:0]       sel_s;
  logic [2:0]       pcnt_s;
  logic [9:0]       hdr_sum_s;
  logic [7:0]       hdr_next_s;
  logic             in_fire_s;
  logic             out_fire_s;

  // Classify each lane of the incoming beat as absent, header or payload.
  always_comb begin
    emit_s = {LANES{1'b0}};
    pcnt_s = 3'd0;
    for (int k = 0; k < LANES; k++) begin
      if (|axis_bitmap_tkeep[k*LANE_K +: LANE_K]) begin
        pcnt_s    = pcnt_s + 3'd1;
        emit_s[k] = (({2'b00, hdr_cnt_r} + 10'(k)) >= HDR_LIM);
      end else begin
        emit_s[k] = 1'b0;
      end
    end
    hdr_sum_s = {2'b00, hdr_cnt_r} + {7'd0, pcnt_s};
    if (hdr_sum_s >= HDR_LIM) begin
      hdr_next_s = HDR_LIM[7:0];
    end else begin
      hdr_next_s = hdr_sum_s[7:0];
    end
  end

  assign sel_s      = lowest_idx(mask_r);
  assign sel_oh_s   = {{(LANES-1){1'b0}}, 1'b1} << sel_s;
  assign out_fire_s = axis_image_tvalid & axis_image_tready;
  assign in_fire_s  = axis_bitmap_tvalid & axis_bitmap_tready;

  // Accept a new beat when the buffer is empty or its last lane leaves this cycle.
  assign axis_bitmap_tready = axis_resetn &
                              ((mask_r == {LANES{1'b0}}) | (is_onehot(mask_r) & axis_image_tready));

  assign axis_image_tvalid = (mask_r != {LANES{1'b0}});
  assign axis_image_tdata  = data_r[sel_s*LANE_W +: LANE_W];
  assign axis_image_tkeep  = keep_r[sel_s*LANE_K +: LANE_K];
  assign axis_image_tlast  = |(last_r & mask_r & sel_oh_s);
  assign axis_image_tuser  = user_r;
  assign pkt_dropped       = drop_r;

  // Holding buffer, header lane count and per-packet emit bookkeeping.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      data_r    <= {TDATA_WIDTH{1'b0}};
      keep_r    <= {(TDATA_WIDTH/8){1'b0}};
      user_r    <= {TUSER_WIDTH{1'b0}};
      mask_r    <= {LANES{1'b0}};
      last_r    <= {LANES{1'b0}};
      hdr_cnt_r <= 8'd0;
      seen_r    <= 1'b0;
      drop_r    <= 1'b0;
    end else begin
      drop_r <= 1'b0;
      if (in_fire_s) begin
        hdr_cnt_r <= axis_bitmap_tlast ? 8'd0 : hdr_next_s;
        if (emit_s != {LANES{1'b0}}) begin
          data_r <= axis_bitmap_tdata;
          keep_r <= axis_bitmap_tkeep;
          user_r <= axis_bitmap_tuser;
          mask_r <= emit_s;
          last_r <= axis_bitmap_tlast ? highest_bit(emit_s) : {LANES{1'b0}};
        end else begin
          mask_r <= {LANES{1'b0}};
          last_r <= {LANES{1'b0}};
        end
        if (axis_bitmap_tlast) begin
          seen_r <= 1'b0;
          drop_r <= (emit_s == {LANES{1'b0}}) & ~seen_r;
        end else if (emit_s != {LANES{1'b0}}) begin
          seen_r <= 1'b1;
        end
      end else if (out_fire_s) begin
        mask_r <= mask_r & ~sel_oh_s;
      end
    end
  end

endmodule
